// File: rtl/mem_writeback_if.sv
// Memory-side bus of the writeback stage: request/acknowledge handshake with address and data.
interface mem_writeback_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_writeback.sv
// Memory-access / writeback / PC-update stage; sequences load-store, register write and fetch request.
// Optional MEM_TIMEOUT_EN: bounded memory wait with sticky mem_error.
module mem_writeback #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 isALUFinished,
  input  logic                 execute_branch,
  input  logic                 jump_flag,
  input  logic [3:0]           opcode,
  input  logic [15:0]          result,
  input  logic [15:0]          rd2,
  input  logic [3:0]           dest_reg,
  input  logic [5:0]           branch_offset,
  input  logic [11:0]          jump_target,
  mem_writeback_if.master      mem,
  output logic                 rf_we,
  output logic [3:0]           rf_waddr,
  output logic [15:0]          rf_wdata,
  output logic [15:0]          pc,
  output logic                 fetchNextInst,
  output logic                 busy,
  output logic                 mem_error
);
  localparam int unsigned XLEN = 16;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RW   = 4;
  localparam int unsigned OFFW = 6;
  localparam int unsigned TGTW = 12;
  localparam int unsigned CNTW = 8;

  typedef enum logic [2:0] {IDLE, MEM, WB, NEXT, WAIT_CLR} state_t;
  typedef enum logic [1:0] {K_ALU, K_BRANCH, K_JUMP} kind_t;

  state_t          state_q, state_n;
  kind_t           kind_q, kind_n, in_kind;
  logic [OPW-1:0]  op_q, op_n;
  logic [XLEN-1:0] res_q, res_n, rd2_q, rd2_n;
  logic [RW-1:0]   dst_q, dst_n;
  logic [OFFW-1:0] off_q, off_n;
  logic [TGTW-1:0] tgt_q, tgt_n;
  logic            mem_req_q, mem_req_n, mem_we_q, mem_we_n;
  logic [XLEN-1:0] mem_addr_q, mem_addr_n, mem_wdata_q, mem_wdata_n;
  logic            rf_we_n, fetch_n, busy_n, err_n;
  logic [RW-1:0]   rf_waddr_n;
  logic [XLEN-1:0] rf_wdata_n, pc_n;
  logic            any_flag, tmo_hit;

  assign any_flag = isALUFinished | execute_branch | jump_flag;
  assign in_kind  = jump_flag ? K_JUMP : (execute_branch ? K_BRANCH : K_ALU);

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  function automatic logic writes_rf(input logic [OPW-1:0] op);
    return (op == OPW'(0)) || (op >= OPW'(2) && op <= OPW'(9));
  endfunction

`ifdef MEM_TIMEOUT_EN
  // Counts MEM cycles without an acknowledge; cleared whenever MEM is left
  logic [CNTW-1:0] tmo_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            tmo_q <= '0;
    else if (state_q == MEM && !mem.mem_ack) tmo_q <= tmo_q + CNTW'(1);
    else                                   tmo_q <= '0;
  end
  assign tmo_hit = (tmo_q == CNTW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^CNTW'(TIMEOUT_CYCLES);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      kind_q        <= K_ALU;
      op_q          <= '0;
      res_q         <= '0;
      rd2_q         <= '0;
      dst_q         <= '0;
      off_q         <= '0;
      tgt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      pc            <= RESET_PC;
      fetchNextInst <= 1'b0;
      busy          <= 1'b0;
      mem_error     <= 1'b0;
    end else begin
      state_q       <= state_n;
      kind_q        <= kind_n;
      op_q          <= op_n;
      res_q         <= res_n;
      rd2_q         <= rd2_n;
      dst_q         <= dst_n;
      off_q         <= off_n;
      tgt_q         <= tgt_n;
      mem_req_q     <= mem_req_n;
      mem_we_q      <= mem_we_n;
      mem_addr_q    <= mem_addr_n;
      mem_wdata_q   <= mem_wdata_n;
      rf_we         <= rf_we_n;
      rf_waddr      <= rf_waddr_n;
      rf_wdata      <= rf_wdata_n;
      pc            <= pc_n;
      fetchNextInst <= fetch_n;
      busy          <= busy_n;
      mem_error     <= err_n;
    end
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_n     = state_q;
    kind_n      = kind_q;
    op_n        = op_q;
    res_n       = res_q;
    rd2_n       = rd2_q;
    dst_n       = dst_q;
    off_n       = off_q;
    tgt_n       = tgt_q;
    mem_req_n   = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;
    rf_we_n     = 1'b0;
    rf_waddr_n  = rf_waddr;
    rf_wdata_n  = rf_wdata;
    pc_n        = pc;
    fetch_n     = 1'b0;
    err_n       = mem_error;

    case (state_q)
      IDLE: begin
        if (any_flag) begin
          kind_n = in_kind;
          op_n   = opcode;
          res_n  = result;
          rd2_n  = rd2;
          dst_n  = dest_reg;
          off_n  = branch_offset;
          tgt_n  = jump_target;
          if (in_kind == K_ALU && opcode <= OPW'(1)) begin
            state_n     = MEM;
            mem_req_n   = 1'b1;
            mem_we_n    = (opcode == OPW'(1));
            mem_addr_n  = result;
            mem_wdata_n = rd2;
          end else begin
            // Register write issued straight from the live inputs to hit WB next cycle
            state_n    = WB;
            rf_we_n    = writes_rf(opcode);
            rf_waddr_n = dest_reg;
            rf_wdata_n = result;
          end
        end
      end
      MEM: begin
        if (mem.mem_ack) begin
          state_n    = WB;
          rf_we_n    = writes_rf(op_q);
          rf_waddr_n = dst_q;
          rf_wdata_n = (op_q == OPW'(0)) ? mem.mem_rdata : res_q;
        end else if (tmo_hit) begin
          state_n    = WB;
          err_n      = 1'b1;
          rf_waddr_n = dst_q;
          rf_wdata_n = res_q;
        end else begin
          mem_req_n = 1'b1;
          mem_we_n  = mem_we_q;
        end
      end
      WB: begin
        state_n = NEXT;
        fetch_n = 1'b1;
        case (kind_q)
          K_JUMP:   pc_n = {pc[XLEN-1:TGTW], tgt_q};
          K_BRANCH: pc_n = pc + XLEN'(1) + {{(XLEN-OFFW){off_q[OFFW-1]}}, off_q};
          default:  pc_n = pc + XLEN'(1);
        endcase
      end
      NEXT:     state_n = WAIT_CLR;
      WAIT_CLR: if (!any_flag) state_n = IDLE;
      default:  state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end
endmodule

// File: tb/tb_mem_writeback.sv
// Scoreboard bench for mem_writeback: random and directed instructions against an arithmetic reference model.
module tb_mem_writeback;
  localparam logic [15:0] RESET_PC       = 16'h0000;
  localparam int unsigned TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        isALUFinished, execute_branch, jump_flag;
  logic [3:0]  opcode, dest_reg;
  logic [15:0] result, rd2;
  logic [5:0]  branch_offset;
  logic [11:0] jump_target;
  logic        rf_we, fetchNextInst, busy, mem_error;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata, pc;

  mem_writeback_if mif();

  mem_writeback #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .isALUFinished(isALUFinished), .execute_branch(execute_branch), .jump_flag(jump_flag),
    .opcode(opcode), .result(result), .rd2(rd2), .dest_reg(dest_reg),
    .branch_offset(branch_offset), .jump_target(jump_target),
    .mem(mif.master),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc(pc), .fetchNextInst(fetchNextInst), .busy(busy), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; int len; } mem_exp_t;
  typedef struct { logic [3:0] waddr; logic [15:0] wdata; int mode; int issue; } rf_exp_t;
  typedef struct { logic [15:0] pc; int mode; int issue; } pc_exp_t;

  mem_exp_t mem_q[$];
  rf_exp_t  rf_q[$];
  pc_exp_t  pc_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          resp_wait = 0;
  logic [15:0] resp_data = '0;
  logic [15:0] model_pc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: acks after resp_wait extra cycles; junk on rdata outside the ack cycle
  initial begin
    int wcnt = 0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = 16'($urandom);
      if (rst_n && mif.mem_req) begin
        if (wcnt == resp_wait) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = resp_data;
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a memory request, register write or fetch
  initial begin
    int       run = 0;
    int       ack_cyc = 0;
    logic     prev_fetch = 1'b0;
    mem_exp_t cur;
    rf_exp_t  r;
    pc_exp_t  p;
    cur.we = 1'b0; cur.addr = '0; cur.wdata = '0; cur.len = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
        prev_fetch = 1'b0;
        continue;
      end
      if (mif.mem_req) begin
        if (run == 0) begin
          check("mem_expected", 32'(mem_q.size() != 0), 1);
          if (mem_q.size() != 0) cur = mem_q.pop_front();
        end
        check("mem_addr", mif.mem_addr, cur.addr);
        check("mem_we", mif.mem_we, cur.we);
        check("mem_wdata", mif.mem_wdata, cur.wdata);
        run++;
        if (mif.mem_ack) ack_cyc = cyc;
      end else if (run != 0) begin
        if (cur.len >= 0) check("mem_req_len", run, cur.len);
        run = 0;
      end
      if (rf_we) begin
        check("rf_expected", 32'(rf_q.size() != 0), 1);
        if (rf_q.size() != 0) begin
          r = rf_q.pop_front();
          check("rf_waddr", rf_waddr, r.waddr);
          check("rf_wdata", rf_wdata, r.wdata);
          check("rf_cycle", cyc, (r.mode == 1) ? ack_cyc + 1 : r.issue + 1);
        end
      end
      if (fetchNextInst) begin
        check("fetch_pulse", prev_fetch, 0);
        check("fetch_expected", 32'(pc_q.size() != 0), 1);
        if (pc_q.size() != 0) begin
          p = pc_q.pop_front();
          check("pc", pc, p.pc);
          if (p.mode == 0) check("fetch_lat_alu", cyc, p.issue + 2);
          else if (p.mode == 1) check("fetch_lat_mem", cyc, ack_cyc + 2);
        end
      end
      prev_fetch = fetchNextInst;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait", busy, 0);
  endtask

  // kind: 0 ALU, 1 branch, 2 jump; extra raises lower-priority flags too; wt<0 means never ack
  task automatic do_op(input int kind, input logic [3:0] op, input logic [15:0] res, input logic [15:0] d2,
                       input logic [3:0] dst, input logic [5:0] off, input logic [11:0] tgt,
                       input int wt, input logic [15:0] rdat, input int hold, input logic extra);
    logic        is_mem, tmo, wr;
    logic [15:0] npc, sext;
    int          issue, n;
    mem_exp_t    m;
    rf_exp_t     r;
    pc_exp_t     p;
    wait_idle();
    is_mem = (kind == 0) && (op <= 4'd1);
    tmo    = is_mem && (wt < 0);
    wr     = ((op == 4'd0) || (op >= 4'd2 && op <= 4'd9)) && !tmo;
    sext   = {{10{off[5]}}, off};
    if (kind == 2)      npc = {model_pc[15:12], tgt};
    else if (kind == 1) npc = model_pc + 16'd1 + sext;
    else                npc = model_pc + 16'd1;
    resp_wait = wt;
    resp_data = rdat;
    opcode = op; result = res; rd2 = d2; dest_reg = dst; branch_offset = off; jump_target = tgt;
    jump_flag      = (kind == 2);
    execute_branch = (kind == 1) || (extra && kind == 2);
    isALUFinished  = (kind == 0) || extra;
    issue = cyc;
    if (is_mem) begin
      m.we = (op == 4'd1); m.addr = res; m.wdata = d2; m.len = tmo ? int'(TIMEOUT_CYCLES) : wt + 1;
      mem_q.push_back(m);
    end
    if (wr) begin
      r.waddr = dst; r.wdata = (is_mem && op == 4'd0) ? rdat : res; r.mode = is_mem ? 1 : 0; r.issue = issue;
      rf_q.push_back(r);
    end
    p.pc = npc; p.mode = tmo ? 2 : (is_mem ? 1 : 0); p.issue = issue;
    pc_q.push_back(p);
    model_pc = npc;
    n = 0;
    do begin
      @(posedge clk); #1;
      opcode = 4'($urandom); result = 16'($urandom); rd2 = 16'($urandom); dest_reg = 4'($urandom);
      branch_offset = 6'($urandom); jump_target = 12'($urandom);
      n++;
    end while (!fetchNextInst && n < 300);
    check("fetch_seen", fetchNextInst, 1);
    repeat (hold) @(posedge clk);
    if (hold > 0) #1;
    isALUFinished = 1'b0; execute_branch = 1'b0; jump_flag = 1'b0;
  endtask

  task automatic reset_mid_mem();
    mem_exp_t m;
    wait_idle();
    resp_wait = 1000;
    opcode = 4'd0; result = 16'h0077; rd2 = 16'h0;
    isALUFinished = 1'b1;
    m.we = 1'b0; m.addr = 16'h0077; m.wdata = 16'h0; m.len = -1;
    mem_q.push_back(m);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_req", mif.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_req", mif.mem_req, 0);
    check("rst_pc", pc, RESET_PC);
    check("rst_busy", busy, 0);
    check("rst_rf_we", rf_we, 0);
    isALUFinished = 1'b0;
    mem_q.delete(); rf_q.delete(); pc_q.delete();
    model_pc = RESET_PC;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    logic [3:0] op;
    rst_n = 1'b0;
    isALUFinished = 1'b0; execute_branch = 1'b0; jump_flag = 1'b0;
    opcode = '0; result = '0; rd2 = '0; dest_reg = '0; branch_offset = '0; jump_target = '0;
    model_pc = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc, RESET_PC);
    check("reset_mem_req", mif.mem_req, 0);
    check("reset_rf_we", rf_we, 0);
    check("reset_fetch", fetchNextInst, 0);
    check("reset_busy", busy, 0);
    check("reset_mem_error", mem_error, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(0, 4'd2, 16'h0042, 16'h1111, 4'd3, 6'd0, 12'h0, 0, 16'h0, 0, 1'b0);
    do_op(0, 4'd0, 16'h0010, 16'h5555, 4'd7, 6'd0, 12'h0, 3, 16'hBEEF, 0, 1'b0);
    do_op(0, 4'd1, 16'h0020, 16'h1234, 4'd9, 6'd0, 12'h0, 1, 16'hDEAD, 0, 1'b0);
    do_op(0, 4'd10, 16'h0001, 16'h0, 4'd1, 6'd0, 12'h0, 0, 16'h0, 0, 1'b0);
    do_op(0, 4'd10, 16'h0002, 16'h0, 4'd1, 6'd0, 12'h0, 0, 16'h0, 0, 1'b0);
    do_op(1, 4'd12, 16'h0003, 16'h0, 4'd2, 6'b111110, 12'h0, 0, 16'h0, 0, 1'b0);
    check("pc_branch_back", pc, 16'h0004);
    do_op(2, 4'd11, 16'h0004, 16'h0, 4'd2, 6'd0, 12'hABC, 0, 16'h0, 5, 1'b1);
    check("pc_jump", pc, 16'h0ABC);

    reset_mid_mem();
    do_op(1, 4'd1, 16'h0005, 16'h0, 4'd5, 6'b111110, 12'h0, 0, 16'h0, 0, 1'b1);
    check("pc_wrap_down", pc, 16'hFFFF);
    do_op(2, 4'd3, 16'h0006, 16'h0, 4'd6, 6'd0, 12'h123, 0, 16'h0, 0, 1'b0);
    check("pc_jump_keep_hi", pc, 16'hF123);
    do_op(1, 4'd4, 16'h0007, 16'h0, 4'd4, 6'b011111, 12'h0, 0, 16'h0, 0, 1'b0);
    check("pc_branch_fwd", pc, 16'hF143);

`ifdef MEM_TIMEOUT_EN
    do_op(0, 4'd0, 16'h0030, 16'h0, 4'd8, 6'd0, 12'h0, -1, 16'h0, 0, 1'b0);
    check("timeout_error", mem_error, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      k  = int'($urandom_range(0, 2));
      op = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 1)) : 4'($urandom);
      if (k != 0 && op == 4'd0) op = 4'd1;
      do_op(k, op, 16'($urandom), 16'($urandom), 4'($urandom), 6'($urandom), 12'($urandom),
            int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end
    repeat (6) @(posedge clk);
    #1;
    check("mem_q_drained", mem_q.size(), 0);
    check("rf_q_drained", rf_q.size(), 0);
    check("pc_q_drained", pc_q.size(), 0);
`ifndef MEM_TIMEOUT_EN
    check("mem_error_tied", mem_error, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_writeback.md
MEM_WRITEBACK -- requirements
Module: mem_writeback

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: memory-wait limit; range 2..255; used only with MEM_TIMEOUT_EN.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 isALUFinished, execute_branch, jump_flag  in  1 each  ALU completion flags, level, held until fetchNextInst.
REQ-006 opcode  in  4  instruction opcode; result  in  16  ALU result or address; rd2  in  16  store data.
REQ-007 dest_reg  in  4  writeback register; branch_offset  in  6  signed offset; jump_target  in  12  jump field.
REQ-008 mem_req  out  1; mem_we  out  1; mem_addr  out  16; mem_wdata  out  16; mem_rdata  in  16; mem_ack  in  1.
REQ-009 rf_we  out  1; rf_waddr  out  4; rf_wdata  out  16: register-file write port.
REQ-010 pc  out  16  program counter; fetchNextInst  out  1  one-cycle pulse; busy  out  1  state != IDLE; mem_error  out  1  sticky.

Function
REQ-011 The FSM SHALL have states IDLE, MEM, WB, NEXT and WAIT_CLR.
REQ-012 In IDLE, if any flag is high, the block SHALL latch opcode, result, rd2, dest_reg, branch_offset and jump_target, and leave IDLE on the next edge.
REQ-013 Priority for simultaneous flags SHALL be: jump_flag, then execute_branch, then isALUFinished.
REQ-014 isALUFinished with opcode 0 (load) or 1 (store) SHALL go to MEM; every other accepted case SHALL go to WB.
REQ-015 In MEM: mem_req=1, mem_addr=latched result, mem_we=1 for a store only, mem_wdata=latched rd2. These SHALL be held stable until the cycle mem_ack=1; then go to WB.
REQ-016 A load SHALL capture mem_rdata in the mem_ack cycle; mem_req SHALL be 0 in the cycle after the ack.
REQ-017 WB SHALL last exactly one cycle; rf_we=1 only for opcodes 0 and 2..9.
REQ-018 rf_wdata SHALL be the load data for opcode 0, else the latched result; rf_waddr SHALL be the latched dest_reg.
REQ-019 PC update in WB: jump -> {pc[15:12], jump_target}; branch -> pc+1+sign-extended branch_offset; otherwise -> pc+1.
REQ-020 All PC arithmetic SHALL be modulo 2^16 (wraps 16'hFFFF+1 -> 16'h0000).
REQ-021 NEXT SHALL assert fetchNextInst for exactly one cycle, then go to WAIT_CLR.
REQ-022 WAIT_CLR SHALL return to IDLE only when all three flags are low; no flag is accepted while in WAIT_CLR.
REQ-023 Latency (no wait states): ALU op, flag seen in cycle N -> rf_we in N+1, fetchNextInst in N+2.
REQ-024 Latency: load/store with mem_ack in cycle M -> WB in M+1, fetchNextInst in M+2.
REQ-025 Flag inputs SHALL be ignored outside IDLE; mem_ack SHALL be ignored outside MEM.

Reset
REQ-026 While rst_n=0 the block SHALL force IDLE, pc=RESET_PC, and all other outputs and latched data to 0, asynchronously.
REQ-027 Reset asserted mid-MEM SHALL drop mem_req in the same instant, with no register write and no PC update.

Configuration
REQ-028 With MEM_TIMEOUT_EN defined, a counter SHALL run in MEM; after TIMEOUT_CYCLES cycles without mem_ack the block SHALL drop mem_req, set mem_error (cleared only by reset), and go to WB with rf_we=0 and pc+1.
REQ-029 Without MEM_TIMEOUT_EN, MEM SHALL wait indefinitely for mem_ack and mem_error SHALL be tied to 0.

Verification
REQ-030 Add: result=16'h0042, dest_reg=3, isALUFinished for one cycle -> next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h0042; pc 0->1; fetchNextInst pulses once.
REQ-031 Load: result=16'h0010, ack after 3 wait cycles, mem_rdata=16'hBEEF -> mem_req held 4 cycles with mem_we=0; rf_wdata=16'hBEEF; pc+1.
REQ-032 Store: result=16'h0020, rd2=16'h1234 -> mem_we=1, mem_addr=16'h0020, mem_wdata=16'h1234; rf_we never asserted.
REQ-033 pc=16'h0005: branch_offset=6'b111110 with execute_branch -> pc=16'h0004; then jump_flag+execute_branch, jump_target=12'hABC -> pc=16'h0ABC.
REQ-034 Reset mid-MEM -> mem_req=0 immediately, pc=RESET_PC.
REQ-035 With MEM_TIMEOUT_EN: no ack -> mem_error=1 after 16 cycles, no register write, pc+1.
REQ-036 Flags held high 5 cycles after fetchNextInst -> no second acceptance.
